// File: rtl/mac_dot.sv
// Pipelined unsigned dot-product MAC: LEN scaled products accumulated, result via valid/ready.
// Optional saturating accumulate with sticky overflow when MAC_SAT_EN is defined.
module mac_dot #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 10,
  parameter int SHIFT = 6,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  x1,
  input  logic [IN_W-1:0]  x2,
  output logic [OUT_W-1:0] m,
  output logic [OUT_W-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [CW-1:0] LEN_C  = CW'(LEN);
  localparam logic [CW-1:0] LAST_C = CW'(LEN - 1);

  typedef enum logic {S_ACCUM = 1'b0, S_DONE = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_issued;
  logic [CW-1:0]     r_summed;
  logic              r_pv;
  logic [OUT_W-1:0]  r_m;
  logic [OUT_W-1:0]  r_y;
  logic [OUT_W-1:0]  w_m;
  logic [OUT_W-1:0]  w_y_nxt;
  logic [2*IN_W-1:0] w_prod;
  logic              w_accept;
  logic              w_hs;
  logic              w_last;

  assign w_prod   = {{IN_W{1'b0}}, x1} * {{IN_W{1'b0}}, x2};
  assign w_m      = OUT_W'(w_prod >> SHIFT);
  assign w_accept = in_valid && in_ready;
  assign w_hs     = (r_state == S_DONE) && out_ready;
  assign w_last   = r_pv && (r_summed == LAST_C);

  assign m         = r_m;
  assign y         = r_y;
  assign out_valid = (r_state == S_DONE);

`ifdef MAC_SAT_EN
  logic [OUT_W:0] w_sum;
  logic           w_ovf_hit;
  logic           r_ovf;

  assign w_sum     = {1'b0, r_y} + {1'b0, r_m};
  assign w_ovf_hit = w_sum[OUT_W];
  assign w_y_nxt   = w_ovf_hit ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0];
  assign ovf       = r_ovf;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_hs) begin
      r_ovf <= 1'b0;
    end else if (r_pv && w_ovf_hit) begin
      r_ovf <= 1'b1;
    end
  end
`else
  assign w_y_nxt = r_y + r_m;
  assign ovf     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      S_ACCUM: begin
        in_ready = (r_issued < LEN_C);
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_state_nxt = S_ACCUM;
      end
      default: w_state_nxt = S_ACCUM;
    endcase
  end

  // Accept and handshake are mutually exclusive: in_ready is low in DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pv     <= 1'b0;
      r_m      <= '0;
      r_y      <= '0;
      r_issued <= '0;
      r_summed <= '0;
    end else begin
      r_pv <= w_accept;
      if (w_accept) begin
        r_m      <= w_m;
        r_issued <= r_issued + 1'b1;
      end
      if (w_hs) begin
        r_y      <= '0;
        r_issued <= '0;
        r_summed <= '0;
      end else if (r_pv) begin
        r_y      <= w_y_nxt;
        r_summed <= r_summed + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_dot.sv
// Directed, table-driven bench for mac_dot at default parameters (8/10/6/4).
module tb_mac_dot;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x1;
  logic [7:0] x2;
  logic [9:0] m;
  logic [9:0] y;
  logic       out_valid;
  logic       out_ready;
  logic       ovf;

  int n_checks = 0;
  int n_errors = 0;

  mac_dot #(.IN_W(8), .OUT_W(10), .SHIFT(6), .LEN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .m         (m),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         exp_m;
    int         exp_y_wrap;
    int         exp_y_sat;
    int         exp_ovf_sat;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int y_exp(input vec_t v);
`ifdef MAC_SAT_EN
    return v.exp_y_sat;
`else
    return v.exp_y_wrap;
`endif
  endfunction

  function automatic int ovf_exp(input vec_t v);
`ifdef MAC_SAT_EN
    return v.exp_ovf_sat;
`else
    return 0;
`endif
  endfunction

  task automatic feed4(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; x1 = a; x2 = b;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_hs_out_valid"}, out_valid, 0);
    check({tag, "_hs_in_ready"}, in_ready, 1);
    check({tag, "_hs_y"}, y, 0);
    check({tag, "_hs_ovf"}, ovf, 0);
  endtask

  initial begin
    vecs[0] = '{8'd16,  8'd16,  4,    16,  16,   0};
    vecs[1] = '{8'd255, 8'd255, 1016, 992, 1023, 1};
    vecs[2] = '{8'd64,  8'd64,  64,   256, 256,  0};
    vecs[3] = '{8'd0,   8'd200, 0,    0,   0,    0};
    vecs[4] = '{8'd100, 8'd50,  78,   312, 312,  0};
    vecs[5] = '{8'd1,   8'd255, 3,    12,  12,   0};
    vecs[6] = '{8'd200, 8'd200, 625,  452, 1023, 1};

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x1 = '0; x2 = '0;
    step(); step();
    reset = 1'b1;
    check("rst_y", y, 0);
    check("rst_m", m, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ovf", ovf, 0);

    for (int v = 0; v < 7; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      in_valid = 1'b1; x1 = vecs[v].a; x2 = vecs[v].b;
      step();
      check({tag, "_m"}, m, vecs[v].exp_m);
      check({tag, "_y_partial"}, y, 0);
      for (int i = 1; i < 4; i++) step();
      in_valid = 1'b0;
      check({tag, "_in_ready_drop"}, in_ready, 0);
      check({tag, "_out_valid_early"}, out_valid, 0);
      step();
      check({tag, "_out_valid"}, out_valid, 1);
      check({tag, "_y"}, y, y_exp(vecs[v]));
      check({tag, "_ovf"}, ovf, ovf_exp(vecs[v]));
      handshake(tag);
    end

    // Backpressure: result must hold while out_ready is low.
    feed4(8'd16, 8'd16);
    step();
    for (int c = 0; c < 5; c++) begin
      check("bp_y", y, 16);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      step();
    end
    handshake("bp");

    // Bubbles in the input stream.
    begin
      logic [6:0] pat;
      pat = 7'b1011001;
      x1 = 8'd64; x2 = 8'd64;
      for (int c = 0; c < 7; c++) begin
        in_valid = pat[c];
        if (pat[c]) check("bub_in_ready", in_ready, 1);
        step();
      end
      in_valid = 1'b0;
      check("bub_in_ready_drop", in_ready, 0);
      step();
      check("bub_out_valid", out_valid, 1);
      check("bub_y", y, 256);
      step();
      check("bub_y_hold", y, 256);
      handshake("bub");
    end

    // Reset in the middle of a dot product.
    in_valid = 1'b1; x1 = 8'd16; x2 = 8'd16;
    step(); step();
    in_valid = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1;
    check("mid_rst_y", y, 0);
    check("mid_rst_m", m, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    step();
    check("mid_rst_y_discard", y, 0);
    feed4(8'd16, 8'd16);
    step();
    check("mid_rst_out_valid2", out_valid, 1);
    check("mid_rst_y2", y, 16);
    handshake("mid_rst");

    // in_valid held through DONE while the result handshake happens.
    feed4(8'd16, 8'd16);
    in_valid = 1'b1; x1 = 8'd64; x2 = 8'd64;
    step();
    check("col_out_valid", out_valid, 1);
    check("col_y", y, 16);
    check("col_m_hold", m, 4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("col_no_accept_m", m, 4);
    check("col_in_ready", in_ready, 1);
    check("col_y_clr", y, 0);
    step();
    in_valid = 1'b0;
    check("col_accept_m", m, 64);
    step();
    check("col_accum_y", y, 64);
    check("col_out_valid_low", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
